// File: rtl/gray_pkg.sv
// gray_pkg: shared state encoding and binary-to-Gray conversion for gray_code_counter
package gray_pkg;
  localparam int GRAY_MAX_W = 64;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/bin_to_gray_param.sv
// bin_to_gray_param: combinational WIDTH-bit binary to Gray converter
module bin_to_gray_param
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  logic [GRAY_MAX_W-1:0] full;
  always_comb full = bin2gray(GRAY_MAX_W'(bin_i));
  assign gray_o = full[WIDTH-1:0];
endmodule

// File: rtl/gray_code_counter.sv
// gray_code_counter: loadable up/down counter presenting registered binary+Gray words over valid/ready.
// Define GRAY_CHECK_EN to build the sticky Gray-adjacency checker driving err.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] g,
  output logic             wrap,
  output logic             err
);
  state_e state_q;
  logic [WIDTH-1:0] cnt_q, bin_q, g_q, nxt_d, pres_d, g_d;
  logic wrap_q, wrap_d, xfer;
  always_comb begin
    nxt_d  = load ? load_val : up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    wrap_d = !load && (up ? cnt_q == {WIDTH{1'b1}} : cnt_q == '0);
    pres_d = (state_q == RUN) ? nxt_d : cnt_q;
    xfer   = (state_q == RUN) && out_ready;
  end
  // Gray is computed from the word about to be registered, so g and bin always load together
  bin_to_gray_param #(.WIDTH(WIDTH)) u_b2g (.bin_i(pres_d), .gray_o(g_d));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      g_q     <= '0;
      wrap_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (load) cnt_q <= load_val;
      else if (en) begin
        bin_q   <= cnt_q;
        g_q     <= g_d;
        wrap_q  <= 1'b0;
        state_q <= RUN;
      end
    end else if (xfer) begin
      cnt_q <= nxt_d;
      if (en) begin
        bin_q  <= nxt_d;
        g_q    <= g_d;
        wrap_q <= wrap_d;
      end else state_q <= IDLE;
    end
  end
`ifdef GRAY_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (xfer && en && !load && $countones(g_d ^ g_q) != 1) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign out_valid = (state_q == RUN);
  assign bin       = bin_q;
  assign g         = g_q;
  assign wrap      = wrap_q;
endmodule

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed self-checking bench for gray_code_counter (WIDTH=4)
module tb_gray_code_counter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0, out_ready = 1'b0;
  logic [3:0] load_val = '0;
  logic out_valid, wrap, err;
  logic [3:0] bin, g;
  int n_chk = 0, n_fail = 0;
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_code_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .out_valid(out_valid), .bin(bin), .g(g), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; out_ready = 1'b0; load_val = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({out_valid, wrap, err, bin, g} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: got v=%b w=%b e=%b bin=%h g=%h, want all zero", out_valid, wrap, err, bin, g);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL up_latency: out_valid=%b before edge, want 0", out_valid);
    end
    for (int k = 0; k <= 16; k++) begin
      step();
      n_chk++;
      if ({out_valid, wrap, err, bin, g} !== {1'b1, k == 16, 1'b0, 4'(k), gtab[k % 16]}) begin
        n_fail++;
        $display("FAIL up_seq[%0d]: got v=%b w=%b e=%b bin=%h g=%h, want v=1 w=%b e=0 bin=%h g=%h",
                 k, out_valid, wrap, err, bin, g, k == 16, 4'(k), gtab[k % 16]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if ({out_valid, wrap, bin, g} !== {1'b1, 1'b0, 4'd5, 4'b0111}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b w=%b bin=%h g=%b, want v=1 w=0 bin=5 g=0111", k, out_valid, wrap, bin, g);
      end
    end
    out_ready = 1'b1;
    step();
    n_chk++;
    if ({out_valid, wrap, bin, g} !== {1'b1, 1'b0, 4'd6, 4'b0101}) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b w=%b bin=%h g=%b, want v=1 w=0 bin=6 g=0101", out_valid, wrap, bin, g);
    end
  endtask

  task automatic test_count_down();
    logic [9:0] exp [3] = '{{1'b1, 1'b0, 4'd0, 4'b0000}, {1'b1, 1'b1, 4'd15, 4'b1000}, {1'b1, 1'b0, 4'd14, 4'b1001}};
    do_reset();
    en = 1'b1; up = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if ({out_valid, wrap, bin, g} !== exp[k]) begin
        n_fail++;
        $display("FAIL down[%0d]: got %b, want %b ({v,w,bin,g})", k, {out_valid, wrap, bin, g}, exp[k]);
      end
    end
  endtask

  task automatic test_load_idle();
    do_reset();
    load = 1'b1; en = 1'b1; load_val = 4'b1010; out_ready = 1'b1;
    step();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_idle_wins: out_valid=%b, want 0", out_valid);
    end
    load = 1'b0;
    step();
    n_chk++;
    if ({out_valid, wrap, bin, g} !== {1'b1, 1'b0, 4'b1010, 4'b1111}) begin
      n_fail++;
      $display("FAIL load_idle: got v=%b w=%b bin=%b g=%b, want v=1 w=0 bin=1010 g=1111", out_valid, wrap, bin, g);
    end
  endtask

  task automatic test_load_run();
    do_reset();
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    repeat (8) step();
    load = 1'b1; load_val = 4'b0011;
    step();
    n_chk++;
    if ({out_valid, wrap, err, bin, g} !== {1'b1, 1'b0, 1'b0, 4'b0011, 4'b0010}) begin
      n_fail++;
      $display("FAIL load_run: got v=%b w=%b e=%b bin=%b g=%b, want v=1 w=0 e=0 bin=0011 g=0010", out_valid, wrap, err, bin, g);
    end
    load = 1'b0;
    step();
    n_chk++;
    if ({bin, g, err} !== {4'd4, 4'b0110, 1'b0}) begin
      n_fail++;
      $display("FAIL load_run_next: got bin=%h g=%b e=%b, want bin=4 g=0110 e=0", bin, g, err);
    end
  endtask

  task automatic test_stop_resume();
    do_reset();
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    en = 1'b0;
    step();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: out_valid=%b, want 0", out_valid);
    end
    en = 1'b1;
    step();
    n_chk++;
    if ({out_valid, bin, g} !== {1'b1, 4'd3, 4'b0010}) begin
      n_fail++;
      $display("FAIL resume: got v=%b bin=%h g=%b, want v=1 bin=3 g=0010", out_valid, bin, g);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    repeat (10) step();
    n_chk++;
    if ({bin, g} !== {4'd9, 4'b1101}) begin
      n_fail++;
      $display("FAIL pre_rst: got bin=%h g=%b, want bin=9 g=1101", bin, g);
    end
    out_ready = 1'b0; rst = 1'b1;
    step();
    n_chk++;
    if ({out_valid, wrap, bin, g} !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b w=%b bin=%h g=%b, want all zero", out_valid, wrap, bin, g);
    end
    rst = 1'b0; out_ready = 1'b1;
    step();
    n_chk++;
    if ({out_valid, bin, g} !== {1'b1, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_restart: got v=%b bin=%h g=%b, want v=1 bin=0 g=0000", out_valid, bin, g);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_backpressure();
    test_count_down();
    test_load_idle();
    test_load_run();
    test_stop_resume();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
